// File: rtl/serializador_pkg.sv
// Shared types and helpers for the PISO serializer and its bit counter.
package serializador_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } estado_e;

    // Counter width for 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/contador_bits.sv
// Bit counter for the serializer: counts consumed bits, flags the last one.
module contador_bits
    import serializador_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic [CntW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/serializador_piso.sv
// Parallel-in/serial-out transmitter with Ready/Load handshake and Shift_en pacing.
module serializador_piso
    import serializador_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Shift_en,
    output logic             Ready,
    output logic             Shift_out,
    output logic             Shift_valid,
    output logic             Done
);

    estado_e          state_d, state_q;
    logic [WIDTH-1:0] hold_d, hold_q;
    logic             shift_out_d, shift_out_q;
    logic             shift_valid_d, shift_valid_q;
    logic             done_d, done_q;

    logic cnt_tc;
    logic cnt_en;
    logic cnt_clr;
    logic last_bit;
    logic accept;

    // Ready opens on the last consumed bit so a new word can follow with no gap.
    assign last_bit = (state_q == StShift) && Shift_en && cnt_tc;
    assign Ready    = (state_q == StIdle) || last_bit;
    assign accept   = Load && Ready;
    assign cnt_en   = (state_q == StShift) && Shift_en;
    assign cnt_clr  = accept || last_bit;

    contador_bits #(
        .WIDTH(WIDTH)
    ) u_contador (
        .clk_i (CLK),
        .rst_ni(Reset_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (Load) begin
                    hold_d  = Data_in;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (Shift_en) begin
                    hold_d = LSB_FIRST ? (hold_q >> 1) : (hold_q << 1);
                    if (cnt_tc) begin
                        done_d = 1'b1;
                        if (Load) begin
                            hold_d = Data_in;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
        endcase
        // Outputs are precomputed from next state so they are registered yet cycle-exact.
        shift_valid_d = (state_d == StShift);
        shift_out_d   = shift_valid_d & (LSB_FIRST ? hold_d[0] : hold_d[WIDTH-1]);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            shift_out_q   <= 1'b0;
            shift_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            shift_out_q   <= shift_out_d;
            shift_valid_q <= shift_valid_d;
            done_q        <= done_d;
        end
    end

    assign Shift_out   = shift_out_q;
    assign Shift_valid = shift_valid_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_serializador_piso.sv
// Scoreboard bench for serializador_piso: directed words, queued expected bits, monitor compare.
module tb_serializador_piso;

    localparam int unsigned W = 4;

    logic         CLK = 1'b0;
    logic         Reset_n;
    logic         Load;
    logic [W-1:0] Data_in;
    logic         Shift_en;
    logic         Ready;
    logic         Shift_out;
    logic         Shift_valid;
    logic         Done;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic         done_exp = 1'b0;
    int           done_seen = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] rx;
    logic [W-1:0] pace_w;

    serializador_piso #(
        .WIDTH    (W),
        .LSB_FIRST(1'b1)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .Load       (Load),
        .Data_in    (Data_in),
        .Shift_en   (Shift_en),
        .Ready      (Ready),
        .Shift_out  (Shift_out),
        .Shift_valid(Shift_valid),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // LSB-first expected bit stream for one word.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.b    = w[k];
            e.last = (k == W - 1);
            exp_q.push_back(e);
        end
    endtask

    // Serial-in receiver clocked on the same edges.
    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rx <= '0;
        end else if (Shift_valid && Shift_en) begin
            rx <= {Shift_out, rx[W-1:1]};
        end
    end

    // Monitor: a bit is consumed on every edge that sees Shift_valid && Shift_en.
    always @(negedge CLK) begin
        if (Reset_n) begin
            if (Done || done_exp) begin
                checks++;
                if (Done !== done_exp) begin
                    errors++;
                    $display("FAIL done_timing: got %b expected %b", Done, done_exp);
                end
                if (Done) done_seen++;
            end
            done_exp = 1'b0;
            if (Shift_valid && Shift_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %b expected no bit", Shift_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    if (Shift_out !== mon_e.b) begin
                        errors++;
                        $display("FAIL serial_bit: got %b expected %b", Shift_out, mon_e.b);
                    end
                    done_exp = mon_e.last;
                end
            end
        end
    end

    initial begin
        Reset_n  = 1'b0;
        Load     = 1'b0;
        Shift_en = 1'b0;
        Data_in  = '0;
        #1;
        chk("rst_ready", Ready, 1);
        chk("rst_valid", Shift_valid, 0);
        chk("rst_out", Shift_out, 0);
        chk("rst_done", Done, 0);
        repeat (2) @(posedge CLK);
        #1 Reset_n = 1'b1;
        tick();

        // 1011, Shift_en high throughout (also high on the load edge, must be ignored)
        Load = 1'b1; Data_in = 4'b1011; Shift_en = 1'b1;
        push_word(4'b1011);
        tick();
        Load = 1'b0; Data_in = '0;
        repeat (4) tick();
        @(negedge CLK);
        chk("rx_word", rx, 4'b1011);
        chk("idle_ready", Ready, 1);
        chk("idle_valid", Shift_valid, 0);
        Shift_en = 1'b0;
        tick();

        // 0110 with Shift_en toggling: each bit held for two cycles
        pace_w = 4'b0110;
        Load = 1'b1; Data_in = pace_w;
        push_word(pace_w);
        tick();
        Load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Shift_en = i[0];
            @(negedge CLK);
            chk("pace_hold", Shift_out, pace_w[i/2]);
            tick();
        end
        Shift_en = 1'b0;
        @(negedge CLK);
        chk("pace_ready", Ready, 1);

        // Back-to-back A then 5 with Load held high
        Shift_en = 1'b1; Load = 1'b1; Data_in = 4'hA;
        push_word(4'hA);
        push_word(4'h5);
        tick();
        Data_in = 4'h5;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("b2b_valid", Shift_valid, 1);
            chk("b2b_ready", Ready, (i == 3 || i == 7) ? 1 : 0);
            tick();
            if (i == 3) begin
                Load = 1'b0; Data_in = '0;
            end
        end
        @(negedge CLK);
        chk("b2b_end_valid", Shift_valid, 0);

        // Load of F during the 2nd bit of 0 must be ignored
        Load = 1'b1; Data_in = 4'h0;
        push_word(4'h0);
        tick();
        Load = 1'b0;
        tick();
        Load = 1'b1; Data_in = 4'hF;
        @(negedge CLK);
        chk("busy_ready", Ready, 0);
        tick();
        Load = 1'b0; Data_in = '0;
        repeat (2) tick();
        @(negedge CLK);
        chk("busy_end_valid", Shift_valid, 0);

        // Abort F after two bits with an asynchronous mid-cycle reset
        Load = 1'b1; Data_in = 4'hF;
        push_word(4'hF);
        tick();
        Load = 1'b0; Data_in = '0;
        repeat (2) tick();
        #1 Reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_ready", Ready, 1);
        chk("abort_valid", Shift_valid, 0);
        chk("abort_out", Shift_out, 0);
        chk("abort_done", Done, 0);
        @(posedge CLK);
        #3 Reset_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_valid", Shift_valid, 0);
        Load = 1'b1; Data_in = 4'h3;
        push_word(4'h3);
        tick();
        Load = 1'b0; Data_in = '0;
        repeat (4) tick();
        @(negedge CLK);
        chk("post_rst_end_valid", Shift_valid, 0);

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses", done_seen, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
